// File: rtl/timer_counter_if.sv
// Bus bundle between the timer count stage and the logic around it.
// master = the side that drives the controls (register block or bench).
// slave  = the timer_counter itself.
// pclk/preset are not carried here; they stay plain ports of the stage.
interface timer_counter_if #(
    parameter int WIDTH = 8
);
    logic             clk_ena;
    logic             cnt_en;
    logic             udt;
    logic             load;
    logic [WIDTH-1:0] tdr;
    logic             ovf_clr;
    logic             udf_clr;
    logic             ovf_ie;
    logic             udf_ie;
    logic [WIDTH-1:0] cmp_val;
    logic             cmp_clr;
    logic [WIDTH-1:0] cnt;
    logic             ovf_flag;
    logic             udf_flag;
    logic             cmp_flag;
    logic             irq;

    modport master (
        output clk_ena, cnt_en, udt, load, tdr, ovf_clr, udf_clr,
               ovf_ie, udf_ie, cmp_val, cmp_clr,
        input  cnt, ovf_flag, udf_flag, cmp_flag, irq
    );

    modport slave (
        input  clk_ena, cnt_en, udt, load, tdr, ovf_clr, udf_clr,
               ovf_ie, udf_ie, cmp_val, cmp_clr,
        output cnt, ovf_flag, udf_flag, cmp_flag, irq
    );
endinterface

// File: rtl/timer_counter.sv
// Timer count stage: up/down counter advanced by the prescaler's clk_ena
// tick, with synchronous load, sticky overflow/underflow flags and a level
// interrupt request. Everything runs on posedge pclk; clk_ena is only a
// count enable.
// Optional feature macro: TMR_CMP_EN adds the sticky compare-match flag.
// Without it cmp_flag is tied 0 and cmp_val/cmp_clr are ignored.
module timer_counter #(
    parameter int WIDTH = 8
) (
    input  logic            pclk,
    input  logic            preset,
    timer_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             tick;
    logic             ovf_set;
    logic             udf_set;
    logic             cmp_term;

    // Next count and flag-set strobes; load beats a tick and suppresses its flags.
    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        tick    = bus.cnt_en & bus.clk_ena;
        if (bus.load) begin
            cnt_d = bus.tdr;
        end else if (tick) begin
            if (!bus.udt) begin
                cnt_d   = cnt_q + ONE;
                ovf_set = (cnt_q == MAX);
            end else begin
                cnt_d   = cnt_q - ONE;
                udf_set = (cnt_q == '0);
            end
        end
        // A set in the same cycle as its clear wins.
        ovf_d = ovf_set | (ovf_q & ~bus.ovf_clr);
        udf_d = udf_set | (udf_q & ~bus.udf_clr);
    end

    // Counter and sticky flag registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

`ifdef TMR_CMP_EN
    logic cmp_q, cmp_d;
    logic cmp_set;

    // Compare match only on a real count step (loads never match), wrap values included.
    always_comb begin
        cmp_set = tick & ~bus.load & (cnt_d == bus.cmp_val);
        cmp_d   = cmp_set | (cmp_q & ~bus.cmp_clr);
    end

    // Sticky compare-match flag register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            cmp_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
        end
    end

    assign cmp_term = cmp_q;
`else
    logic unused_cmp;
    assign unused_cmp = ^{bus.cmp_val, bus.cmp_clr};
    assign cmp_term   = 1'b0;
`endif

    assign bus.cnt      = cnt_q;
    assign bus.ovf_flag = ovf_q;
    assign bus.udf_flag = udf_q;
    assign bus.cmp_flag = cmp_term;
    // Enables only gate the request; the flags themselves are never touched by them.
    assign bus.irq      = (ovf_q & bus.ovf_ie) | (udf_q & bus.udf_ie) | cmp_term;
endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed vectors with literal expectations, plus
// an arithmetic reference model compared against the DUT every cycle.
// Build with or without +define+TMR_CMP_EN; the bench follows the macro.
module tb_timer_counter;
    localparam int W = 8;
`ifdef TMR_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic pclk   = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    timer_counter_if #(.WIDTH(W)) bus ();
    timer_counter #(.WIDTH(W)) dut (.pclk(pclk), .preset(preset), .bus(bus));

    int compared   = 0;
    int mismatched = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Count kept as a plain integer; wrap is detected by leaving 0..2**W-1.
    int m_cnt;
    bit m_ovf, m_udf, m_cmp, m_live;
    int m_nxt;
    bit m_ov, m_un, m_cm;

    always @(posedge pclk) begin
        if (preset) begin
            m_cnt = 0; m_ovf = 0; m_udf = 0; m_cmp = 0; m_live = 1;
        end else begin
            m_nxt = m_cnt; m_ov = 0; m_un = 0; m_cm = 0;
            if (bus.load) begin
                m_nxt = int'(bus.tdr);
            end else if (bus.cnt_en && bus.clk_ena) begin
                m_nxt = bus.udt ? m_cnt - 1 : m_cnt + 1;
                if (m_nxt >= (1 << W)) begin m_nxt = 0;            m_ov = 1; end
                if (m_nxt < 0)         begin m_nxt = (1 << W) - 1; m_un = 1; end
                m_cm = CMP_EN && (m_nxt == int'(bus.cmp_val));
            end
            m_cnt = m_nxt;
            m_ovf = m_ov || (m_ovf && !bus.ovf_clr);
            m_udf = m_un || (m_udf && !bus.udf_clr);
            m_cmp = m_cm || (m_cmp && !bus.cmp_clr);
        end
    end

    // Compare process: outputs are stable mid-cycle.
    always @(negedge pclk) begin
        if (m_live) begin
            check("model_cnt", 32'(bus.cnt), 32'(m_cnt));
            check("model_ovf", 32'(bus.ovf_flag), 32'(m_ovf));
            check("model_udf", 32'(bus.udf_flag), 32'(m_udf));
            check("model_cmp", 32'(bus.cmp_flag), 32'(m_cmp));
            check("model_irq", 32'(bus.irq),
                  32'((m_ovf && bus.ovf_ie) || (m_udf && bus.udf_ie) || m_cmp));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        bus.tdr  = v;
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic tick_pop(input string name);
        cyc();
        if (exp_q.size() == 0) check({name, "_queue_empty"}, 32'd1, 32'd0);
        else                   check(name, 32'(bus.cnt), 32'(exp_q.pop_front()));
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bus.clk_ena = 0; bus.cnt_en = 0; bus.udt = 0; bus.load = 0; bus.tdr = '0;
        bus.ovf_clr = 0; bus.udf_clr = 0; bus.ovf_ie = 0; bus.udf_ie = 0;
        bus.cmp_val = 8'hAA; bus.cmp_clr = 0;
        preset = 1'b1;
        cyc(2);
        preset = 1'b0;
        check("rst_cnt", 32'(bus.cnt), 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);

        // 1: reset mid-count at 0x37
        do_load(8'h30);
        bus.cnt_en = 1; bus.clk_ena = 1; bus.udt = 0;
        cyc(7);
        check("t1_cnt_37", 32'(bus.cnt), 32'h37);
        preset = 1'b1;
        cyc();
        preset = 1'b0;
        bus.clk_ena = 0;
        check("t1_rst_cnt", 32'(bus.cnt), 32'h0);
        check("t1_rst_ovf", 32'(bus.ovf_flag), 32'h0);
        check("t1_rst_irq", 32'(bus.irq), 32'h0);

        // 2: up wrap
        do_load(8'hFE);
        bus.ovf_ie = 1; bus.udt = 0; bus.clk_ena = 1;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        tick_pop("t2_cnt_ff");
        check("t2_ovf_before", 32'(bus.ovf_flag), 32'h0);
        tick_pop("t2_cnt_00");
        bus.clk_ena = 0;
        check("t2_ovf", 32'(bus.ovf_flag), 32'h1);
        check("t2_irq", 32'(bus.irq), 32'h1);

        // 3: down wrap; ovf stays set
        do_load(8'h01);
        bus.udt = 1; bus.clk_ena = 1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        tick_pop("t3_cnt_00");
        tick_pop("t3_cnt_ff");
        bus.clk_ena = 0;
        check("t3_udf", 32'(bus.udf_flag), 32'h1);
        check("t3_ovf_kept", 32'(bus.ovf_flag), 32'h1);
        bus.ovf_ie = 0;
        #1 check("t3_irq_gated", 32'(bus.irq), 32'h0);
        bus.udf_ie = 1;
        #1 check("t3_irq_udf", 32'(bus.irq), 32'h1);
        bus.ovf_clr = 1; bus.udf_clr = 1;
        cyc();
        bus.ovf_clr = 0; bus.udf_clr = 0;
        check("t3_ovf_clr", 32'(bus.ovf_flag), 32'h0);
        check("t3_udf_clr", 32'(bus.udf_flag), 32'h0);

        // 4: load beats tick; hold with cnt_en=0
        do_load(8'h10);
        bus.udt = 0; bus.clk_ena = 1; bus.cnt_en = 1;
        do_load(8'h80);
        check("t4_load_wins", 32'(bus.cnt), 32'h80);
        bus.cnt_en = 0;
        cyc(3);
        check("t4_hold", 32'(bus.cnt), 32'h80);
        bus.cnt_en = 1; bus.clk_ena = 0;
        cyc(2);
        check("t4_no_tick_hold", 32'(bus.cnt), 32'h80);
        // load of 0xFF with tick: no overflow on the load cycle
        bus.clk_ena = 1;
        do_load(8'hFF);
        bus.clk_ena = 0;
        check("t4_load_noflag", 32'(bus.ovf_flag), 32'h0);

        // 5: set/clear race, set wins
        bus.udt = 0; bus.clk_ena = 1; bus.ovf_clr = 1;
        cyc();
        bus.clk_ena = 0;
        check("t5_race_cnt", 32'(bus.cnt), 32'h00);
        check("t5_race_set", 32'(bus.ovf_flag), 32'h1);
        cyc();
        bus.ovf_clr = 0;
        check("t5_clear", 32'(bus.ovf_flag), 32'h0);

        // 6: compare
        bus.cmp_val = 8'h05;
        do_load(8'h03);
        bus.clk_ena = 1;
        cyc();
        check("t6_cmp_at_04", 32'(bus.cmp_flag), 32'h0);
        cyc();
        bus.clk_ena = 0;
        check("t6_cnt_05", 32'(bus.cnt), 32'h05);
        check("t6_cmp_set", 32'(bus.cmp_flag), 32'(CMP_EN));
        check("t6_cmp_irq", 32'(bus.irq), 32'(CMP_EN));
        bus.cmp_clr = 1;
        cyc();
        bus.cmp_clr = 0;
        check("t6_cmp_clr", 32'(bus.cmp_flag), 32'h0);
        do_load(8'h05);
        check("t6_load_nomatch", 32'(bus.cmp_flag), 32'h0);
        // wrap value match on underflow
        bus.cmp_val = 8'hFF;
        do_load(8'h00);
        bus.udt = 1; bus.clk_ena = 1;
        cyc();
        bus.clk_ena = 0;
        check("t6_wrap_cmp", 32'(bus.cmp_flag), 32'(CMP_EN));
        check("t6_wrap_udf", 32'(bus.udf_flag), 32'h1);

        // random burst, checked by the model
        for (int i = 0; i < 300; i++) begin
            bus.clk_ena = 1'($urandom_range(0, 1));
            bus.cnt_en  = ($urandom_range(0, 5) != 0);
            bus.udt     = 1'($urandom_range(0, 1));
            bus.load    = ($urandom_range(0, 9) == 0);
            bus.tdr     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            bus.ovf_clr = ($urandom_range(0, 5) == 0);
            bus.udf_clr = ($urandom_range(0, 5) == 0);
            bus.cmp_clr = ($urandom_range(0, 5) == 0);
            bus.ovf_ie  = 1'($urandom_range(0, 1));
            bus.udf_ie  = 1'($urandom_range(0, 1));
            bus.cmp_val = 8'($urandom_range(0, 3));
            preset      = ($urandom_range(0, 60) == 0);
            cyc();
        end
        preset = 0; bus.load = 0; bus.ovf_clr = 0; bus.udf_clr = 0; bus.cmp_clr = 0;

        // reset with flags set
        bus.cnt_en = 1; bus.clk_ena = 1; bus.udt = 0;
        do_load(8'hFF);
        cyc();
        check("rst2_ovf_pre", 32'(bus.ovf_flag), 32'h1);
        preset = 1;
        cyc();
        preset = 0; bus.clk_ena = 0;
        check("rst2_cnt", 32'(bus.cnt), 32'h0);
        check("rst2_ovf", 32'(bus.ovf_flag), 32'h0);
        check("rst2_irq", 32'(bus.irq), 32'h0);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
